id_hazard_ctrl: RTL and testbench

//  Sequences the decode stage: decides each cycle whether the instruction in ID issues to EX, stalls, or is

---
 rtl/id_hazard_ctrl_pkg.sv | 17 +
 rtl/id_hazard_ctrl_load_scoreboard.sv | 61 ++++++
 rtl/id_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_id_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_hazard_ctrl_pkg : shared decode-stage hazard control types              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RST_HOLD = 2'd0,
    HZ_RUN      = 2'd1,
    HZ_FLUSH    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/id_hazard_ctrl_load_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_scoreboard : pending-load bit per register plus in-flight load count  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module load_scoreboard
  import id_hazard_ctrl_pkg::*;
#(
  parameter int MAX_LOADS = 4,
  localparam int CW = $clog2(MAX_LOADS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_set,
  input  logic [4:0]    i_set_rd,
  input  logic          i_clr,
  input  logic [4:0]    i_clr_rd,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic [4:0]    i_rd,
  output logic          o_pend_rs1,
  output logic          o_pend_rs2,
  output logic          o_pend_rd,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] c_max = CW'(MAX_LOADS);

  logic [31:0]   r_pend;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      // Clear first so a same-index set in the same cycle wins.
      if (i_clr) r_pend[i_clr_rd] <= 1'b0;
      if (i_set && (i_set_rd != REG_X0)) r_pend[i_set_rd] <= 1'b1;

      case ({i_set, i_clr})
        2'b10: if (r_count != c_max) r_count <= r_count + 1'b1;
        2'b01: if (r_count != '0)    r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_pend_rs1 = r_pend[i_rs1];
  assign o_pend_rs2 = r_pend[i_rs2];
  assign o_pend_rd  = r_pend[i_rd];
  assign o_full     = (r_count == c_max);
  assign o_count    = r_count;

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_clr && !i_set) |-> (r_count != '0))
    else $error("load writeback with no load in flight");

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_hazard_ctrl : decode-stage issue / stall / squash sequencing            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int MAX_LOADS    = 4,
  parameter int FLUSH_CYCLES = 2,
  localparam int CW = $clog2(MAX_LOADS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_id_valid,
  input  logic [4:0]    i_id_rs1,
  input  logic [4:0]    i_id_rs2,
  input  logic          i_id_uses_rs1,
  input  logic          i_id_uses_rs2,
  input  logic [4:0]    i_id_rd,
  input  logic          i_id_is_reg_write,
  input  logic          i_id_is_load,
  input  logic          i_ex_redirect,
  input  logic          i_mem_busy,
  input  logic          i_wb_load_done,
  input  logic [4:0]    i_wb_load_rd,
  output logic          o_issue,
  output logic          o_pc_stall,
  output logic          o_ifid_stall,
  output logic          o_ifid_flush,
  output logic          o_idex_bubble,
  output logic          o_exmem_stall,
  output logic [CW-1:0] o_loads_inflight
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] c_flush_load = FCW'(FLUSH_CYCLES);

  hz_state_t      r_state, w_state_nxt;
  logic [FCW-1:0] r_flush_cnt, w_flush_cnt_nxt;

  logic w_pend_rs1, w_pend_rs2, w_pend_rd, w_full;
  logic w_hazard;

  load_scoreboard #(.MAX_LOADS(MAX_LOADS)) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set      (o_issue & i_id_is_load),
    .i_set_rd   (i_id_rd),
    .i_clr      (i_wb_load_done),
    .i_clr_rd   (i_wb_load_rd),
    .i_rs1      (i_id_rs1),
    .i_rs2      (i_id_rs2),
    .i_rd       (i_id_rd),
    .o_pend_rs1 (w_pend_rs1),
    .o_pend_rs2 (w_pend_rs2),
    .o_pend_rd  (w_pend_rd),
    .o_full     (w_full),
    .o_count    (o_loads_inflight)
  );

  // Destination check guards WAW against an older load still outstanding.
  assign w_hazard = (i_id_uses_rs1     && (i_id_rs1 != REG_X0) && w_pend_rs1)
                  | (i_id_uses_rs2     && (i_id_rs2 != REG_X0) && w_pend_rs2)
                  | (i_id_is_reg_write && (i_id_rd  != REG_X0) && w_pend_rd)
                  | (i_id_is_load      && w_full);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= HZ_RST_HOLD;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    o_issue         = 1'b0;
    o_pc_stall      = 1'b0;
    o_ifid_stall    = 1'b0;
    o_ifid_flush    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_exmem_stall   = i_mem_busy;

    // A busy memory freezes the whole back-end, including the flush countdown.
    case (r_state)
      HZ_RST_HOLD: w_state_nxt = HZ_RUN;
      HZ_RUN: begin
        if (i_ex_redirect && !i_mem_busy) begin
          w_state_nxt     = HZ_FLUSH;
          w_flush_cnt_nxt = c_flush_load;
        end
      end
      HZ_FLUSH: begin
        if (!i_mem_busy) begin
          if (i_ex_redirect) begin
            w_flush_cnt_nxt = c_flush_load;
          end else if (r_flush_cnt <= FCW'(1)) begin
            w_state_nxt     = HZ_RUN;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = HZ_RST_HOLD;
    endcase

    if (r_state == HZ_RST_HOLD) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (i_mem_busy) begin
      o_pc_stall   = 1'b1;
      o_ifid_stall = 1'b1;
    end else if (i_ex_redirect || (r_state == HZ_FLUSH)) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (i_id_valid && w_hazard) begin
      o_pc_stall    = 1'b1;
      o_ifid_stall  = 1'b1;
      o_idex_bubble = 1'b1;
    end else if (i_id_valid) begin
      o_issue = 1'b1;
    end else begin
      o_idex_bubble = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_hazard_ctrl : directed + random bench against a queue-based model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_id_hazard_ctrl;

  localparam int MAX_LOADS    = 4;
  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, uses1, uses2, wr, ld, redir, busy, wbd;
  logic [4:0] rs1, rs2, rd, wbrd;
  logic       o_issue, o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble, o_exmem_stall;
  logic [2:0] o_loads_inflight;

  int n_chk = 0;
  int n_err = 0;

  // Model: outstanding load destinations in issue order, plus pipeline mode.
  int q[$];
  bit hold;
  int flush_left;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.MAX_LOADS(MAX_LOADS), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
    .i_id_rd(rd), .i_id_is_reg_write(wr), .i_id_is_load(ld),
    .i_ex_redirect(redir), .i_mem_busy(busy),
    .i_wb_load_done(wbd), .i_wb_load_rd(wbrd),
    .o_issue(o_issue), .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall),
    .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble),
    .o_exmem_stall(o_exmem_stall), .o_loads_inflight(o_loads_inflight)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    valid = 0; uses1 = 0; uses2 = 0; wr = 0; ld = 0; redir = 0; busy = 0; wbd = 0;
    rs1 = 0; rs2 = 0; rd = 0; wbrd = 0;
  endtask

  task automatic instr(input logic [4:0] s1, input logic [4:0] d, input bit is_ld);
    valid = 1; rs1 = s1; uses1 = 1; rs2 = 0; uses2 = 0; rd = d; wr = 1; ld = is_ld;
  endtask

  // Checks every output against the model for the currently driven inputs,
  // advances the model, then waits for the next falling edge.
  task automatic cyc();
    bit haz, e_iss, e_pc, e_ifs, e_fl, e_bub;
    int idx;
    #1;
    haz = (uses1 && pending(rs1)) || (uses2 && pending(rs2)) ||
          (wr && pending(rd)) || (ld && q.size() == MAX_LOADS);
    e_iss = 0; e_pc = 0; e_ifs = 0; e_fl = 0; e_bub = 0;
    if (hold) begin
      e_fl = 1; e_bub = 1;
    end else if (busy) begin
      e_pc = 1; e_ifs = 1;
    end else if (redir || flush_left > 0) begin
      e_fl = 1; e_bub = 1;
    end else if (valid && haz) begin
      e_pc = 1; e_ifs = 1; e_bub = 1;
    end else if (valid) begin
      e_iss = 1;
    end else begin
      e_bub = 1;
    end
    chk("issue",       int'(o_issue),       int'(e_iss));
    chk("pc_stall",    int'(o_pc_stall),    int'(e_pc));
    chk("ifid_stall",  int'(o_ifid_stall),  int'(e_ifs));
    chk("ifid_flush",  int'(o_ifid_flush),  int'(e_fl));
    chk("idex_bubble", int'(o_idex_bubble), int'(e_bub));
    chk("exmem_stall", int'(o_exmem_stall), int'(busy));
    chk("loads",       int'(o_loads_inflight), q.size());

    if (wbd && q.size() > 0) begin
      idx = 0;
      foreach (q[i]) if (q[i] == int'(wbrd)) idx = i;
      q.delete(idx);
    end
    if (e_iss && ld) q.push_back(int'(rd));
    if (hold) hold = 0;
    else if (!busy) begin
      if (redir) flush_left = FLUSH_CYCLES;
      else if (flush_left > 0) flush_left--;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    q.delete(); hold = 1; flush_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset release: bubble+flush first, then issue.
    instr(5'd1, 5'd3, 0); cyc(); cyc();

    // Load-use: lw x5 then add x5 stalls until the cycle after writeback.
    instr(5'd1, 5'd5, 1); cyc();
    instr(5'd5, 5'd6, 0); cyc(); cyc();
    wbd = 1; wbrd = 5; cyc();
    wbd = 0; cyc();

    // Load capacity: four loads fill, fifth waits for a writeback.
    for (int r = 1; r <= 4; r++) begin instr(5'd0, 5'(r), 1); cyc(); end
    instr(5'd0, 5'd6, 1); cyc();
    wbd = 1; wbrd = 1; cyc();
    wbd = 0; cyc();
    idle();
    for (int r = 2; r <= 4; r++) begin wbd = 1; wbrd = 5'(r); cyc(); end
    wbd = 1; wbrd = 6; cyc();
    wbd = 0;

    // Redirect: three squashed cycles, then issue resumes.
    instr(5'd1, 5'd2, 0); redir = 1; cyc();
    redir = 0; cyc(); cyc(); cyc();

    // Memory busy dominates redirect and hazard.
    instr(5'd0, 5'd9, 1); cyc();
    instr(5'd9, 5'd10, 0); busy = 1; redir = 1; cyc(); cyc(); cyc();
    busy = 0; redir = 0; cyc();
    wbd = 1; wbrd = 9; cyc();
    wbd = 0; cyc();

    // Same-cycle writeback and new load to x7.
    instr(5'd0, 5'd0, 1); cyc();
    instr(5'd0, 5'd7, 1); wbd = 1; wbrd = 7; cyc();
    wbd = 0; instr(5'd7, 5'd8, 0); cyc();

    // Asynchronous reset mid-cycle clears everything.
    rst_n = 0;
    #1;
    chk("rst_loads", int'(o_loads_inflight), 0);
    chk("rst_flush", int'(o_ifid_flush), 1);
    chk("rst_issue", int'(o_issue), 0);
    q.delete(); hold = 1; flush_left = 0;
    #1 rst_n = 1;
    idle();
    cyc(); instr(5'd7, 5'd8, 0); cyc();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      valid = ($urandom_range(0, 9) < 8);
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 7));
      uses1 = 1'($urandom_range(0, 1));
      uses2 = 1'($urandom_range(0, 1));
      ld    = ($urandom_range(0, 2) == 0);
      wr    = ld | 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 11) == 0);
      busy  = ($urandom_range(0, 7) == 0);
      wbd   = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      wbrd  = wbd ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 31));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
